// File: rtl/bench_seq_ctrl.sv
// bench_seq_ctrl: LFSR pattern sequencer that flushes, drives and signs (MISR) a 4-input DUT.
// Defining BENCH_SEQ_GOLDEN_CMP_EN adds a golden-response input and a saturating mismatch counter.
module bench_seq_ctrl #(
    parameter int LAT = 2
) (
    input  logic       I1294_clk,
    input  logic       I1342_rst,
    input  logic       start,
    input  logic [7:0] num_vec,
    input  logic [3:0] seed,
    output logic [3:0] dut_in,
    output logic       dut_rst_n,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] signature
`ifdef BENCH_SEQ_GOLDEN_CMP_EN
    ,
    input  logic       exp_out,
    output logic [7:0] mism_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_APPLY = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(LAT - 1);

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic bit_in);
        return {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ {7'b0, bit_in};
    endfunction

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_lfsr;
    logic [3:0]     r_dut_in;
    logic [8:0]     r_cnt;
    logic [2:0]     r_tick;
    logic [LAT-1:0] r_vld_sr;
    logic [7:0]     r_sig;
    logic           r_busy;
    logic           r_done;
    logic           r_dut_rst_n;
    logic           w_accept;
    logic           w_apply;
    logic           w_capture;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_apply   = (r_state == S_APPLY);
    assign w_capture = r_vld_sr[LAT-1];

    assign dut_in    = r_dut_in;
    assign dut_rst_n = r_dut_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_sig;

    // State register.
    always_ff @(posedge I1294_clk or negedge I1342_rst) begin
        if (!I1342_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; r_tick counts cycles spent in the current state.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FLUSH;
                else       w_next_state = S_IDLE;
            end
            S_FLUSH: begin
                if (r_tick == 3'd1) w_next_state = S_APPLY;
                else                w_next_state = S_FLUSH;
            end
            S_APPLY: begin
                if (r_cnt == 9'd1) w_next_state = S_DRAIN;
                else               w_next_state = S_APPLY;
            end
            S_DRAIN: begin
                if (r_tick == LAT_LAST) w_next_state = S_DONE;
                else                    w_next_state = S_DRAIN;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Registered outputs, pattern generator, vector counter, capture delay line and MISR.
    always_ff @(posedge I1294_clk or negedge I1342_rst) begin
        if (!I1342_rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dut_rst_n <= 1'b0;
            r_dut_in    <= 4'h0;
            r_lfsr      <= 4'h1;
            r_cnt       <= 9'd0;
            r_tick      <= 3'd0;
            r_vld_sr    <= '0;
            r_sig       <= 8'h00;
        end else begin
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
            r_dut_rst_n <= (w_next_state != S_FLUSH);
            r_dut_in    <= (w_next_state == S_APPLY) ? r_lfsr : 4'h0;
            r_tick      <= (w_next_state != r_state) ? 3'd0 : r_tick + 3'd1;
            r_vld_sr    <= LAT'({r_vld_sr, w_apply});
            // r_lfsr runs one step ahead of dut_in so the pattern leaves a flop.
            if (w_accept) begin
                r_lfsr <= (seed == 4'h0) ? 4'h1 : seed;
                r_cnt  <= (num_vec == 8'd0) ? 9'd256 : {1'b0, num_vec};
            end else begin
                if (w_next_state == S_APPLY) r_lfsr <= lfsr_step(r_lfsr);
                if (w_apply)                 r_cnt  <= r_cnt - 9'd1;
            end
            if (w_accept)       r_sig <= 8'h00;
            else if (w_capture) r_sig <= misr_step(r_sig, dut_out);
        end
    end

`ifdef BENCH_SEQ_GOLDEN_CMP_EN
    logic [7:0] r_mism_cnt;

    assign mism_cnt = r_mism_cnt;

    // Saturating count of captured responses that differ from the golden bit.
    always_ff @(posedge I1294_clk or negedge I1342_rst) begin
        if (!I1342_rst) begin
            r_mism_cnt <= 8'd0;
        end else if (w_accept) begin
            r_mism_cnt <= 8'd0;
        end else if (w_capture && (dut_out != exp_out) && (r_mism_cnt != 8'hFF)) begin
            r_mism_cnt <= r_mism_cnt + 8'd1;
        end
    end
`endif

endmodule
